// File: rtl/clock_divider_if.sv
// clock_divider_if: ratio in, divided clock out.
// master drives div_val, slave returns clk_out.
interface clock_divider_if #(
  parameter int N = 8
);
  logic [N-1:0] div_val;
  logic         clk_out;

  modport master (
    output div_val,
    input  clk_out
  );

  modport slave (
    input  div_val,
    output clk_out
  );
endinterface

// File: rtl/clock_divider.sv
// clock_divider: runtime-programmable 50% duty divider.
// Period is 2*floor(div_val/2) cycles, output registered.
module clock_divider #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  clock_divider_if.slave  bus
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] half;
  logic [N-1:0] tc;
  logic         valid;
  logic [N-1:0] count;
  logic         clk_q;

  // half-period terminal count from the live ratio
  always_comb begin
    half  = bus.div_val >> 1;
    tc    = half - ONE;
    valid = (half != '0);
  end

  // half-period counter and toggle flop; >= lets a
  // shrinking ratio wrap at once instead of overrunning
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      clk_q <= 1'b0;
    end else if (!valid) begin
      count <= '0;
      clk_q <= 1'b0;
    end else if (count >= tc) begin
      count <= '0;
      clk_q <= ~clk_q;
    end else begin
      count <= count + ONE;
    end
  end

  assign bus.clk_out = clk_q;

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed vectors into a scoreboard,
// monitor pops and compares on each falling edge.
module tb_clock_divider;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string        name;
    logic         out;
    logic [N-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  clock_divider_if #(.N(N)) bus ();

  clock_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_now(
    input string        nm,
    input logic         o,
    input logic [N-1:0] c
  );
    exp_t e;
    e.name = nm;
    e.out  = o;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // called at a falling edge; one rising edge per call
  task automatic step(
    input string        nm,
    input logic [N-1:0] dv,
    input logic         o,
    input logic [N-1:0] c
  );
    bus.div_val = dv;
    @(posedge clk);
    #1;
    expect_now(nm, o, c);
    @(negedge clk);
  endtask

  // from count=0/out=0: after edge e, out=(e/h)%2, count=e%h
  task automatic run_half(
    input string        nm,
    input logic [N-1:0] dv,
    input int           h,
    input int           edges
  );
    for (int e = 1; e <= edges; e++)
      step(nm, dv, logic'((e / h) % 2), N'(e % h));
  endtask

  task automatic reset_pulse(input logic [N-1:0] dv);
    rst = 1'b0;
    step("rst_pulse", dv, 1'b0, '0);
    rst = 1'b1;
  endtask

  // monitor: compare DUT against queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.clk_out !== e.out) begin
        errors++;
        $display("FAIL %s clk_out: got %0b want %0b",
                 e.name, bus.clk_out, e.out);
      end
      checks++;
      if (dut.count !== e.cnt) begin
        errors++;
        $display("FAIL %s count: got %0d want %0d",
                 e.name, dut.count, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    bus.div_val = N'(4);
    @(negedge clk);

    // held in reset
    step("reset_hold", N'(4), 1'b0, '0);
    step("reset_hold", N'(4), 1'b0, '0);
    rst = 1'b1;

    // div 4: 0,1,1,0,...
    run_half("div4", N'(4), 2, 18);

    // one more edge: e=19 -> out high, count 1
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_now("async_rst", 1'b0, '0);
    @(negedge clk);
    step("async_hold", N'(4), 1'b0, '0);
    rst = 1'b1;

    // div 2: toggle every edge
    run_half("div2", N'(2), 1, 8);
    reset_pulse(N'(2));

    // div 7: half=3, period 6
    run_half("div7", N'(7), 3, 12);
    reset_pulse(N'(7));

    // div 10 up to count=4, then shrink to 4
    run_half("div10", N'(10), 5, 4);
    for (int n = 1; n <= 8; n++)
      step("div10to4", N'(4),
           logic'(((n + 1) / 2) % 2), N'((n + 1) % 2));

    // invalid ratios force low
    for (int i = 0; i < 10; i++)
      step("div1", N'(1), 1'b0, '0);
    for (int i = 0; i < 10; i++)
      step("div0", N'(0), 1'b0, '0);

    // recover with div 6: first rise at edge 3
    run_half("div6", N'(6), 3, 9);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
# clock_divider

Programmable integer clock divider. It produces a registered 50%-duty square wave `clk_out` whose period is `2*floor(div_val/2)` input clock cycles. It sits at the clock-generation edge of a design, deriving slower strobes or clocks from the system clock under runtime control. The output is a register output and is glitch-free.

## Interface
- `N`, default 8: width of `div_val` and of the internal half-period counter.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted). Removal is synchronous to `clk`.
- `div_val`  input  N  division ratio `k`. Sampled every cycle. Valid range is 2..2^N-1.
- `clk_out`  output  1  divided clock, registered.

## Operation
- Internal term `half = div_val >> 1` (N bits). Terminal count `tc = half - 1`.
- Internal state:
  - `count`: N-bit half-period counter.
  - `clk_out` register.
- Reset (`rst`=0, asynchronous):
  - `count` = 0 and `clk_out` = 0 immediately.
  - Both hold while `rst` is low.
- Normal operation, when `half` ≥ 1, on each rising `clk`:
  - If `count >= tc`: `count` ← 0 and `clk_out` ← ~`clk_out`.
  - Otherwise: `count` ← `count` + 1.
  - `>=` is used rather than `==`, so a shrinking `div_val` never causes a 2^N-cycle overrun.
- Output period and duty:
  - Even `k`: period = `k` cycles, exactly `k/2` high and `k/2` low.
  - Odd `k`: truncates to `k-1` (e.g. `k`=3 gives period 2, `k`=5 gives period 4).
  - `k`=2: `clk_out` toggles every cycle.
- Invalid `div_val` (0 or 1, so `half` = 0):
  - `count` is forced to 0 and `clk_out` is forced to 0.
  - The output stays low and no toggling occurs.
- Runtime change of `div_val`:
  - No internal reset occurs.
  - The new `tc` takes effect from the next rising edge.
  - If the current `count` is already ≥ the new `tc`, the next edge toggles `clk_out` and clears `count`.
- No other state, and no FSM beyond the counter and the toggle flop.

## Timing
- After reset release, the first rising edge with `half` ≥ 1 starts counting from `count`=0.
- The first toggle (0→1) lands on the `half`-th rising edge after release. Toggles then repeat every `half` rising edges.
- `clk_out` changes only on rising `clk`, at clock-to-Q after the edge. No combinational path from `div_val` to `clk_out`.
- Reset asserted mid-period: `clk_out` drops to 0 asynchronously. Counting restarts from 0 after release.
- Reset released coincident with a `clk` edge: that edge is ignored (`count` stays 0).

## Test plan
- Reset:
  - Stimulus: `rst`=0 for 2 cycles with `div_val`=4.
  - Required: `clk_out`=0 and `count`=0 throughout. `rst` low asynchronously mid-cycle forces `clk_out`=0 without waiting for an edge.
- `div_val`=4 after reset release:
  - Required: `clk_out` reads 0,1,1,0,0,1,1,0… sampled after successive edges. First rise at edge 2, period 4, duty 2/2, for 16 cycles.
- `div_val`=2:
  - Required: `clk_out` toggles on every rising edge, period 2.
- `div_val`=7 (odd):
  - Required: `half`=3, so toggles every 3 edges. Period 6, 3 high / 3 low.
- `div_val`=10, then changed to 4 while `count`=4 without reset:
  - Required: the next edge toggles `clk_out` and clears `count`. Thereafter toggles every 2 edges.
- `div_val`=1 and then 0 for 10 cycles each:
  - Required: `clk_out` stays 0. Switching back to `div_val`=6 toggles first after 3 edges.
